output_drain: RTL and testbench
===============================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter NumberofPixels, default 19'd19200, pixels in the equalized image.
REQ-002 SHALL have parameter AddressSize, default 16, output-memory address width.
REQ-003 SHALL have parameter DataBusSize, default 128, output-memory word width (16 pixels of 8 bits).
REQ-004 clock  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 GlobalFlag  input  2  pipeline status from Control; 2'b11 = image complete.
REQ-007 ReadAddressOutput  output  AddressSize  output-memory word address.
REQ-008 ReadEnableOutput  output  1  output-memory read strobe.
REQ-009 ReadBusOutput  input  DataBusSize  output-memory read data, one cycle after strobe.
REQ-010 PixelData  output  8  streamed pixel.
REQ-011 PixelValid  output  1  PixelData valid.
REQ-012 PixelReady  input  1  sink accepts; a transfer occurs on an edge with PixelValid&PixelReady.
REQ-013 PixelLast  output  1  high with the final pixel.
REQ-014 DrainDone  output  1  level, high after the final transfer.
REQ-015 Checksum  output  16  pixel sum (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE, READ, CAPTURE, STREAM, DONE.
REQ-017 IDLE: when GlobalFlag==2'b11 is sampled -> READ; otherwise stay.
REQ-018 READ: assert ReadEnableOutput for exactly one cycle with the current word address -> CAPTURE.
REQ-019 CAPTURE: register ReadBusOutput into a 128-bit shift register at the end of the cycle -> STREAM.
REQ-020 Timing: flag sampled at edge t0; strobe during t0..t1; data captured at t2; PixelValid high from t2.
REQ-021 STREAM: PixelData = shift register bits [7:0]; byte 0 of each word is streamed first.
REQ-022 Backpressure: while PixelValid&!PixelReady, PixelData and PixelLast are held stable.
REQ-023 On each transfer: shift right 8, increment the 19-bit pixel counter, and increment the 4-bit byte index.
REQ-024 Word rollover: transfer of byte 15 with pixels remaining -> READ with the word address incremented; this gives a 2-cycle bubble.
REQ-025 A partial final word, when NumberofPixels is not a multiple of 16, stops after pixel NumberofPixels-1; the unused bytes are discarded.
REQ-026 PixelLast is high iff pixel counter == NumberofPixels-1 while PixelValid.
REQ-027 Transfer of the last pixel -> DONE; PixelValid low; DrainDone high.
REQ-028 DONE: hold until GlobalFlag!=2'b11 is sampled -> IDLE, clearing DrainDone, the counters and the address; this prevents a double drain.
REQ-029 GlobalFlag changes during READ/CAPTURE/STREAM are ignored; the drain completes.
REQ-030 ReadAddressOutput = 0 in IDLE; the address is held outside READ.

Reset
REQ-031 reset low asynchronously forces IDLE and sets every output, counter, shift register and the checksum to 0, including mid-drain.
REQ-032 After reset release, the FSM waits in IDLE for a fresh GlobalFlag==2'b11.

Configuration
REQ-033 With macro DRAIN_CHECKSUM_EN defined, Checksum = modulo-2^16 sum of all transferred pixels; it is cleared on leaving IDLE and is final when DrainDone is high.
REQ-034 Without DRAIN_CHECKSUM_EN, the Checksum port exists and is driven constant 0, with no accumulator logic.

Structure
REQ-035 A shared package SHALL hold the state encoding, the GlobalFlag done code 2'b11, and the pixel width 8.
REQ-036 A single sub-module drain_shifter (128-bit load/shift register with byte index) is natural; the FSM stays in output_drain.

Verification
REQ-037 NumberofPixels=32, PixelReady=1, flag 2'b11: 2 strobes at address 0,1; 32 pixels in byte order; PixelLast on pixel 31; DrainDone high.
REQ-038 Random PixelReady stalls: the data sequence is identical to REQ-037 and PixelData is stable during each stall.
REQ-039 NumberofPixels=20: 2 words read; exactly 20 transfers; bytes 4-15 of word 1 are never emitted.
REQ-040 reset asserted after pixel 10: all outputs are 0 immediately; the drain restarts from address 0 on the next flag.
REQ-041 DRAIN_CHECKSUM_EN set, all 32 pixels = 8'hFF: Checksum=16'h1FE0; with the macro undefined, Checksum=0.
REQ-042 Flag held at 2'b11 after DONE: no second drain; flag to 2'b00 then 2'b11 starts a new drain.

Source files
------------

// File: rtl/output_drain_pkg.sv
// Shared definitions for the output drain: FSM encoding, Control's "image complete" code and
// the pixel width.
package output_drain_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StStream,
    StDone
  } state_e;

  localparam logic [1:0] FlagDone = 2'b11;
  localparam int unsigned PixelWidth = 8;

endpackage

// File: rtl/output_drain_if.sv
// Output-memory read port plus the pixel stream, status and checksum of the drain.
// master = the drain itself, slave = memory/sink/control side.
interface output_drain_if #(
  parameter int unsigned AddressSize = 16,
  parameter int unsigned DataBusSize = 128
);
  logic [1:0]             GlobalFlag;
  logic [AddressSize-1:0] ReadAddressOutput;
  logic                   ReadEnableOutput;
  logic [DataBusSize-1:0] ReadBusOutput;
  logic [7:0]             PixelData;
  logic                   PixelValid;
  logic                   PixelReady;
  logic                   PixelLast;
  logic                   DrainDone;
  logic [15:0]            Checksum;

  modport master (
    input  GlobalFlag, ReadBusOutput, PixelReady,
    output ReadAddressOutput, ReadEnableOutput, PixelData, PixelValid, PixelLast, DrainDone,
           Checksum
  );

  modport slave (
    output GlobalFlag, ReadBusOutput, PixelReady,
    input  ReadAddressOutput, ReadEnableOutput, PixelData, PixelValid, PixelLast, DrainDone,
           Checksum
  );
endinterface

// File: rtl/output_drain_shifter.sv
// Word-wide load/shift register for the drain: presents the lowest byte and counts bytes
// consumed from the current word.
module output_drain_shifter
  import output_drain_pkg::*;
#(
  parameter int unsigned DataBusSize = 128,
  parameter int unsigned IndexWidth  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [DataBusSize-1:0] i_data,
  output logic [PixelWidth-1:0]  o_byte,
  output logic [IndexWidth-1:0]  o_index
);

  logic [DataBusSize-1:0] r_data;
  logic [IndexWidth-1:0]  r_index;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_index <= '0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_index <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_index <= '0;
    end else if (i_shift) begin
      r_data  <= r_data >> PixelWidth;
      r_index <= r_index + 1'b1;
    end
  end

  assign o_byte  = r_data[PixelWidth-1:0];
  assign o_index = r_index;

endmodule

// File: rtl/output_drain.sv
// Streams the equalized image out of output memory one pixel per handshake, 16 pixels per word.
// Optional pixel checksum accumulator enabled by defining DRAIN_CHECKSUM_EN.
module output_drain
  import output_drain_pkg::*;
#(
  parameter logic [18:0] NumberofPixels = 19'd19200,
  parameter int unsigned AddressSize    = 16,
  parameter int unsigned DataBusSize    = 128
) (
  input  logic            clock,
  input  logic            reset,
  output_drain_if.master  bus
);

  localparam int unsigned IndexWidth = $clog2(DataBusSize / PixelWidth);
  localparam logic [18:0] LastPixel  = NumberofPixels - 19'd1;

  state_e                 r_state, w_state_next;
  logic [AddressSize-1:0] r_addr, w_addr_next;
  logic [18:0]            r_count, w_count_next;
  logic                   w_xfer, w_last, w_load, w_clear;
  logic [PixelWidth-1:0]  w_byte;
  logic [IndexWidth-1:0]  w_index;

  output_drain_shifter #(
    .DataBusSize (DataBusSize),
    .IndexWidth  (IndexWidth)
  ) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_shift (w_xfer),
    .i_data  (bus.ReadBusOutput),
    .o_byte  (w_byte),
    .o_index (w_index)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_count <= w_count_next;
    end
  end

  assign w_xfer = (r_state == StStream) && bus.PixelReady;
  assign w_last = (r_count == LastPixel);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_count_next = r_count;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.GlobalFlag == FlagDone) w_state_next = StRead;
      end
      StRead:    w_state_next = StCapture;
      StCapture: begin
        w_load       = 1'b1;
        w_state_next = StStream;
      end
      StStream: begin
        if (w_xfer) begin
          w_count_next = r_count + 19'd1;
          if (w_last) begin
            w_state_next = StDone;
          end else if (&w_index) begin
            // Word exhausted with pixels remaining: fetch the next word.
            w_state_next = StRead;
            w_addr_next  = r_addr + 1'b1;
          end
        end
      end
      StDone: begin
        // Flag must drop before re-arming, so one completion yields exactly one drain.
        if (bus.GlobalFlag != FlagDone) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
          w_count_next = '0;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.ReadEnableOutput  = (r_state == StRead);
  assign bus.ReadAddressOutput = r_addr;
  assign bus.PixelData         = w_byte;
  assign bus.PixelValid        = (r_state == StStream);
  assign bus.PixelLast         = (r_state == StStream) && w_last;
  assign bus.DrainDone         = (r_state == StDone);

`ifdef DRAIN_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if ((r_state == StIdle) && (w_state_next == StRead)) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      r_sum <= r_sum + {8'd0, w_byte};
    end
  end

  assign bus.Checksum = r_sum;
`else
  assign bus.Checksum = 16'd0;
`endif

endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain: a 32-pixel instance and a 20-pixel (partial word) instance.
module tb_output_drain;

  logic clk;
  logic rst_n;

  output_drain_if #(.AddressSize(16), .DataBusSize(128)) if_a ();
  output_drain_if #(.AddressSize(16), .DataBusSize(128)) if_b ();

  output_drain #(.NumberofPixels(19'd32), .AddressSize(16), .DataBusSize(128)) u_dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (if_a)
  );

  output_drain #(.NumberofPixels(19'd20), .AddressSize(16), .DataBusSize(128)) u_dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] mem_a [2];
  logic [127:0] mem_b [2];

  // Output memory: data returned one cycle after the strobe.
  always @(posedge clk) begin
    if (if_a.ReadEnableOutput) if_a.ReadBusOutput <= mem_a[if_a.ReadAddressOutput[0]];
    if (if_b.ReadEnableOutput) if_b.ReadBusOutput <= mem_b[if_b.ReadAddressOutput[0]];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] got_data [$];
  bit         got_last [$];
  int         got_addr [$];
  int         got_cyc  [$];
  int         str_cyc  [$];
  bit         timeout;
  int         stall_bad;
  int         n_stalls;

  // Runs one drain on instance sel, recording transfers and strobes.
  task automatic collect(input bit sel, input bit stall, input int max_xfers);
    bit   r, v, l, en, dn, prev_stalled, fin;
    logic [7:0] d, held_d;
    bit   held_l;
    int   a, cyc;
    got_data.delete(); got_last.delete(); got_addr.delete();
    got_cyc.delete();  str_cyc.delete();
    timeout = 1'b1; stall_bad = 0; n_stalls = 0; prev_stalled = 1'b0; fin = 1'b0;
    held_d = 8'd0; held_l = 1'b0; cyc = 0;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      r = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sel) if_b.PixelReady = r; else if_a.PixelReady = r;
      v  = sel ? if_b.PixelValid : if_a.PixelValid;
      d  = sel ? if_b.PixelData : if_a.PixelData;
      l  = sel ? if_b.PixelLast : if_a.PixelLast;
      en = sel ? if_b.ReadEnableOutput : if_a.ReadEnableOutput;
      a  = sel ? int'(if_b.ReadAddressOutput) : int'(if_a.ReadAddressOutput);
      dn = sel ? if_b.DrainDone : if_a.DrainDone;
      if (prev_stalled && (d !== held_d || l !== held_l)) stall_bad++;
      prev_stalled = v && !r;
      if (prev_stalled) n_stalls++;
      held_d = d; held_l = l;
      if (en) begin got_addr.push_back(a); str_cyc.push_back(cyc); end
      if (v && r) begin got_data.push_back(d); got_last.push_back(l); got_cyc.push_back(cyc); end
      if (dn || got_data.size() >= max_xfers) begin fin = 1'b1; timeout = 1'b0; end
    end
  endtask

  task automatic test_reset();
    if ({if_a.PixelValid, if_a.ReadEnableOutput, if_a.PixelLast, if_a.DrainDone} !== 4'b0) begin
      $display("FAIL reset_ctrl: got %b required 0000",
               {if_a.PixelValid, if_a.ReadEnableOutput, if_a.PixelLast, if_a.DrainDone});
      errors++;
    end
    checks++;
    if (if_a.ReadAddressOutput !== 16'd0 || if_a.PixelData !== 8'd0) begin
      $display("FAIL reset_addr_data: got addr %0h data %0h required 0 0",
               if_a.ReadAddressOutput, if_a.PixelData);
      errors++;
    end
    checks++;
    if (if_a.Checksum !== 16'd0) begin
      $display("FAIL reset_checksum: got %0h required 0", if_a.Checksum); errors++;
    end
    checks++;
  endtask

  task automatic test_full_drain();
    int exp_sum;
    if_a.GlobalFlag = 2'b11;
    collect(1'b0, 1'b0, 1000);
    if (timeout) begin $display("FAIL full_timeout: drain never completed"); errors++; end
    checks++;
    if (got_data.size() != 32) begin
      $display("FAIL full_count: got %0d transfers required 32", got_data.size()); errors++;
    end
    checks++;
    for (int i = 0; i < 32 && i < got_data.size(); i++) begin
      if (got_data[i] !== 8'(i + 1) || got_last[i] !== (i == 31)) begin
        $display("FAIL full_pixel[%0d]: got %0h last %0b required %0h last %0b",
                 i, got_data[i], got_last[i], i + 1, i == 31);
        errors++;
      end
      checks++;
    end
    if (got_addr.size() != 2 || got_addr[0] != 0 || got_addr[1] != 1) begin
      $display("FAIL full_strobes: got %0d strobes required 2 at addr 0,1", got_addr.size());
      errors++;
    end
    checks++;
    if (str_cyc.size() < 1 || got_cyc.size() < 17 || str_cyc[0] != 1 || got_cyc[0] != 3) begin
      $display("FAIL full_latency: strobe/valid cycles wrong, required 1 and 3"); errors++;
    end
    checks++;
    if (got_cyc.size() >= 17 && got_cyc[16] - got_cyc[15] != 3) begin
      $display("FAIL full_bubble: got gap %0d required 3", got_cyc[16] - got_cyc[15]); errors++;
    end
    checks++;
    if (if_a.DrainDone !== 1'b1 || if_a.PixelValid !== 1'b0) begin
      $display("FAIL full_done: got done %b valid %b required 1 0", if_a.DrainDone,
               if_a.PixelValid);
      errors++;
    end
    checks++;
`ifdef DRAIN_CHECKSUM_EN
    exp_sum = 528;
`else
    exp_sum = 0;
`endif
    if (if_a.Checksum !== 16'(exp_sum)) begin
      $display("FAIL full_checksum: got %0h required %0h", if_a.Checksum, exp_sum); errors++;
    end
    checks++;
  endtask

  task automatic test_no_redrain();
    int strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_a.ReadEnableOutput) strobes++;
    end
    if (strobes != 0 || if_a.DrainDone !== 1'b1) begin
      $display("FAIL hold_flag: got %0d strobes done %b required 0 1", strobes, if_a.DrainDone);
      errors++;
    end
    checks++;
    if_a.GlobalFlag = 2'b00;
    repeat (2) @(negedge clk);
    if (if_a.DrainDone !== 1'b0 || if_a.ReadAddressOutput !== 16'd0) begin
      $display("FAIL rearm_idle: got done %b addr %0h required 0 0", if_a.DrainDone,
               if_a.ReadAddressOutput);
      errors++;
    end
    checks++;
  endtask

  task automatic test_stall();
    if_a.GlobalFlag = 2'b11;
    collect(1'b0, 1'b1, 1000);
    if (timeout || got_data.size() != 32) begin
      $display("FAIL stall_count: got %0d transfers required 32", got_data.size()); errors++;
    end
    checks++;
    for (int i = 0; i < 32 && i < got_data.size(); i++) begin
      if (got_data[i] !== 8'(i + 1) || got_last[i] !== (i == 31)) begin
        $display("FAIL stall_pixel[%0d]: got %0h last %0b required %0h last %0b",
                 i, got_data[i], got_last[i], i + 1, i == 31);
        errors++;
      end
      checks++;
    end
    if (stall_bad != 0 || n_stalls == 0) begin
      $display("FAIL stall_hold: got %0d unstable of %0d stalls required 0 of >0",
               stall_bad, n_stalls);
      errors++;
    end
    checks++;
    if_a.GlobalFlag = 2'b00;
    if_a.PixelReady = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_partial();
    int extra = 0;
    if_b.GlobalFlag = 2'b11;
    collect(1'b1, 1'b0, 1000);
    if (timeout || got_data.size() != 20) begin
      $display("FAIL partial_count: got %0d transfers required 20", got_data.size()); errors++;
    end
    checks++;
    for (int i = 0; i < 20 && i < got_data.size(); i++) begin
      if (got_data[i] !== 8'(i + 1) || got_last[i] !== (i == 19)) begin
        $display("FAIL partial_pixel[%0d]: got %0h last %0b required %0h last %0b",
                 i, got_data[i], got_last[i], i + 1, i == 19);
        errors++;
      end
      checks++;
    end
    if (got_addr.size() != 2 || got_addr[0] != 0 || got_addr[1] != 1) begin
      $display("FAIL partial_strobes: got %0d strobes required 2 at addr 0,1", got_addr.size());
      errors++;
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_b.PixelValid) extra++;
    end
    if (extra != 0 || if_b.DrainDone !== 1'b1) begin
      $display("FAIL partial_tail: got %0d extra valid done %b required 0 1", extra,
               if_b.DrainDone);
      errors++;
    end
    checks++;
    if_b.GlobalFlag = 2'b00;
  endtask

  task automatic test_reset_mid();
    if_a.GlobalFlag = 2'b11;
    collect(1'b0, 1'b0, 11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if ({if_a.PixelValid, if_a.PixelLast, if_a.DrainDone, if_a.ReadEnableOutput} !== 4'b0 ||
        if_a.PixelData !== 8'd0 || if_a.ReadAddressOutput !== 16'd0 || if_a.Checksum !== 16'd0)
    begin
      $display("FAIL midreset_outputs: got valid %b data %0h addr %0h sum %0h required all 0",
               if_a.PixelValid, if_a.PixelData, if_a.ReadAddressOutput, if_a.Checksum);
      errors++;
    end
    checks++;
    if_a.GlobalFlag = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if (if_a.ReadEnableOutput !== 1'b0 || if_a.PixelValid !== 1'b0) begin
      $display("FAIL midreset_idle: got en %b valid %b required 0 0", if_a.ReadEnableOutput,
               if_a.PixelValid);
      errors++;
    end
    checks++;
    if_a.GlobalFlag = 2'b11;
    collect(1'b0, 1'b0, 1000);
    if (timeout || got_data.size() != 32 || got_data[0] !== 8'd1) begin
      $display("FAIL midreset_restart: got %0d transfers required 32 from pixel 1",
               got_data.size());
      errors++;
    end
    checks++;
    if (got_addr.size() != 2 || got_addr[0] != 0 || got_addr[1] != 1) begin
      $display("FAIL midreset_addr: got %0d strobes required 2 at addr 0,1", got_addr.size());
      errors++;
    end
    checks++;
    if_a.GlobalFlag = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_checksum();
    logic [15:0] exp_sum;
    mem_a[0] = {128{1'b1}};
    mem_a[1] = {128{1'b1}};
`ifdef DRAIN_CHECKSUM_EN
    exp_sum = 16'h1FE0;
`else
    exp_sum = 16'h0000;
`endif
    if_a.GlobalFlag = 2'b11;
    collect(1'b0, 1'b0, 1000);
    if (timeout || got_data.size() != 32) begin
      $display("FAIL cksum_count: got %0d transfers required 32", got_data.size()); errors++;
    end
    checks++;
    if (if_a.Checksum !== exp_sum) begin
      $display("FAIL cksum_ff: got %0h required %0h", if_a.Checksum, exp_sum); errors++;
    end
    checks++;
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 16; b++) begin
        mem_a[w][b*8 +: 8] = 8'(w * 16 + b + 1);
        mem_b[w][b*8 +: 8] = 8'(w * 16 + b + 1);
      end
    end
    rst_n = 1'b0;
    if_a.GlobalFlag = 2'b00; if_a.PixelReady = 1'b0; if_a.ReadBusOutput = '0;
    if_b.GlobalFlag = 2'b00; if_b.PixelReady = 1'b0; if_b.ReadBusOutput = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_full_drain();
    test_no_redrain();
    test_stall();
    test_partial();
    test_reset_mid();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
